// File: rtl/qdec_pkg.sv
// qdec_pkg: shared types and phase helpers for the quadrature decoder.
// Phase encoding is {a, b}; the up direction walks 00 -> 01 -> 11 -> 10 -> 00.
package qdec_pkg;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } qdec_state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Phase that follows ph when the encoder turns one quarter-step upward.
  function automatic logic [1:0] next_up_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit.
// Both stages clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: turns encoder phases (a, b) into one-cycle step strobes
// with direction, a BITS-wide wrapping position count Q and a sticky error flag.
// Optional build macro: QDEC_GLITCH_FILTER_EN adds a FILT_LEN-sample stability
// filter between the synchronizers and the decoder.
module quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int FILT_LEN = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a,
  input  logic            b,
  input  logic            enable,
  input  logic            clear,
  output logic            step,
  output logic            dir,
  output logic [BITS-1:0] Q,
  output logic            err
);

`ifdef QDEC_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  // The synchronizers (and filter, if present) hold reset zeros for a few
  // cycles after release, so priming waits until they carry the real inputs.
  localparam int PRIME_LAST = 2 + (FILT_EN ? FILT_LEN : 0);
  localparam int PW         = $clog2(PRIME_LAST + 1);

  logic        a_s;
  logic        b_s;
  logic [1:0]  sync_phase;
  logic [1:0]  phase;
  logic [1:0]  prev_phase;
  logic [1:0]  prev_nxt;
  logic [PW-1:0] pcnt;

  qdec_state_t state;
  qdec_state_t state_nxt;

  logic            step_nxt;
  logic            dir_nxt;
  logic [BITS-1:0] q_nxt;
  logic            err_nxt;

  sync_2ff u_sync_a (.clk(clk), .reset_n(reset_n), .d(a), .q(a_s));
  sync_2ff u_sync_b (.clk(clk), .reset_n(reset_n), .d(b), .q(b_s));

  assign sync_phase = {a_s, b_s};

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int RW = $clog2(FILT_LEN + 1);

  logic [1:0]    cand;
  logic [1:0]    filt;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;

  // Count consecutive identical samples, saturating at FILT_LEN.
  always_comb begin
    run_nxt = RW'(1);
    if (sync_phase == cand) begin
      if (run >= RW'(FILT_LEN)) begin
        run_nxt = RW'(FILT_LEN);
      end else begin
        run_nxt = run + 1'b1;
      end
    end
  end

  // Accept a phase only once it has been seen FILT_LEN times in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= PH_00;
      run  <= '0;
      filt <= PH_00;
    end else begin
      cand <= sync_phase;
      run  <= run_nxt;
      if (run_nxt == RW'(FILT_LEN)) begin
        filt <= sync_phase;
      end
    end
  end

  assign phase = filt;
`else
  assign phase = sync_phase;
`endif

  // State register plus the priming counter that runs while UNPRIMED.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= UNPRIMED;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == UNPRIMED) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Leave UNPRIMED once the phase pipeline reflects the real inputs.
  always_comb begin
    state_nxt = state;
    case (state)
      UNPRIMED: if (pcnt == PW'(PRIME_LAST)) state_nxt = TRACK;
      default:  state_nxt = TRACK;
    endcase
  end

  // Decode the transition from prev_phase to phase; clear overrides Q and err.
  always_comb begin
    step_nxt = 1'b0;
    dir_nxt  = dir;
    q_nxt    = Q;
    err_nxt  = err;
    prev_nxt = phase;
    if (state == TRACK && phase != prev_phase) begin
      if (phase == next_up_phase(prev_phase)) begin
        dir_nxt  = 1'b1;
        step_nxt = enable;
        if (enable) q_nxt = Q + 1'b1;
      end else if (prev_phase == next_up_phase(phase)) begin
        dir_nxt  = 1'b0;
        step_nxt = enable;
        if (enable) q_nxt = Q - 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end
    if (clear) begin
      q_nxt   = '0;
      err_nxt = 1'b0;
    end
  end

  // Register all outputs so step is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step       <= 1'b0;
      dir        <= 1'b1;
      Q          <= '0;
      err        <= 1'b0;
      prev_phase <= PH_00;
    end else begin
      step       <= step_nxt;
      dir        <= dir_nxt;
      Q          <= q_nxt;
      err        <= err_nxt;
      prev_phase <= prev_nxt;
    end
  end

endmodule
